ram_dp_mem: RTL and testbench
=============================

Name: ram_dp_mem

Overview:
Parametrised simple dual-port RAM. It is the next generation of the team's single-port RAM. It adds:
- separate write and read ports, usable in the same cycle
- per-byte write enables
- a selectable read-during-write mode
- an optional output register
- a built-in clear sequencer that zeroes the whole array after every reset
It is the generic on-chip buffer for datapath stages and FIFOs in the design.

Parameters:
DATA_WIDTH, 8, word width in bits; must be an integer multiple of BYTE_WIDTH.
ADDR_WIDTH, 6, address width; depth = 2**ADDR_WIDTH words.
BYTE_WIDTH, 8, lane width for byte enables; NUM_BE = DATA_WIDTH/BYTE_WIDTH.
RDW_MODE, 0, same-address read during write: 0 returns new (merged) data, 1 returns old data.
OUT_REG, 0, 0 gives read latency 1; 1 adds an output register, giving latency 2.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  write request; sampled only when init_busy=0.
wr_addr  in  ADDR_WIDTH  write address.
wr_data  in  DATA_WIDTH  write data.
wr_be  in  NUM_BE  byte enables; bit i writes lane [i*BYTE_WIDTH +: BYTE_WIDTH].
rd_en  in  1  read request; sampled only when init_busy=0.
rd_addr  in  ADDR_WIDTH  read address.
rd_data  out  DATA_WIDTH  read data; holds last value when no read completes.
rd_valid  out  1  one-cycle pulse marking rd_data as new.
init_busy  out  1  high while the clear sequencer runs.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rd_data=0, rd_valid=0, init_busy=1
  - FSM=CLEAR, clear counter=0
  - read pipeline flushed
  - array contents are not reset directly; the clear sequencer zeroes them.
- FSM states: CLEAR and RUN.
- CLEAR state:
  - Each rising edge writes all-zero to address clr_cnt and increments clr_cnt.
  - At the edge that writes address 2**ADDR_WIDTH-1, FSM goes to RUN and init_busy falls.
  - Clear therefore takes exactly 2**ADDR_WIDTH edges after rst_n rises.
  - No wrap of the counter beyond the last address.
- CLEAR/RUN handshake:
  - While init_busy=1, wr_en and rd_en are ignored: writes are dropped and no rd_valid is generated.
  - A request presented in the same cycle that init_busy is still 1 is dropped, not queued.
- RUN state, write:
  - When wr_en=1 at an edge, only lanes with wr_be[i]=1 are updated.
  - wr_be=0 with wr_en=1 is a no-op.
- RUN state, read:
  - rd_en=1 at edge N registers rd_addr.
  - OUT_REG=0: rd_data is valid after edge N+1, with rd_valid=1 for that cycle.
  - OUT_REG=1: rd_data and rd_valid appear one edge later (N+2).
  - rd_valid is a pure delay of the accepted rd_en.
  - Back-to-back reads give one result per cycle.
- Read-during-write to the same address in the same cycle:
  - RDW_MODE=0: the result equals old word with the enabled lanes replaced by wr_data (lane-wise bypass).
  - RDW_MODE=1: the result equals the word before the write.
  - Different addresses do not interact.
- rd_data is registered, never combinational from the address inputs. It changes only when a read completes or on reset.
- Reset asserted mid-operation (CLEAR or RUN):
  - Takes effect immediately; in-flight reads are discarded and rd_valid=0.
  - After release, the full clear sequence restarts from address 0.
- Addresses are ADDR_WIDTH bits and cover the full depth; no out-of-range case exists.

Test Plan:
1. Clear check (defaults): release rst_n, count edges -> init_busy falls after exactly 64 edges; then read addresses 0..63 -> all rd_data=0x00 with rd_valid one cycle after each rd_en.
2. Byte enables (DATA_WIDTH=32, BYTE_WIDTH=8):
   - write 0xAABBCCDD, wr_be=4'b1111, to addr 5
   - write 0x11223344, wr_be=4'b0101, to addr 5
   - read addr 5 -> 0xAA22CC44.
3. Read-during-write (DATA_WIDTH=8): addr 9 holds 0x3C; in one cycle write 0xA5 to addr 9 and read addr 9 -> 0xA5 with RDW_MODE=0, 0x3C with RDW_MODE=1; next read -> 0xA5 in both modes.
4. Latency and streaming:
   - OUT_REG=1: rd_en high for 4 cycles on addrs 0..3 after writing 0x10..0x13 -> rd_valid high for 4 consecutive cycles, starting 2 edges after the first rd_en, with data 0x10, 0x11, 0x12, 0x13 in order.
   - rd_data holds 0x13 afterwards.
5. Requests during clear: assert wr_en (addr 7, 0xFF) and rd_en while init_busy=1 -> rd_valid stays 0; after clear, read addr 7 -> 0x00.
6. Reset mid-operation: write 0x77 to addr 2 in RUN, issue rd_en, then pulse rst_n low before rd_valid -> rd_valid stays 0, init_busy=1; after the 64-edge clear, addr 2 reads 0x00.

Source files
------------

// File: rtl/ram_dp_mem.sv
// ram_dp_mem: simple dual-port RAM with byte enables, selectable read-during-write,
// optional output register and a clear sequencer that zeroes the array after reset.
module ram_dp_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     wr_be,
    input  logic                                 rd_en,
    input  logic [ADDR_WIDTH-1:0]                rd_addr,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 rd_valid,
    output logic                                 init_busy
);
    localparam int NUM_BE = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   wr_word_d;
    logic [DATA_WIDTH-1:0]   rd_word_d;
    logic [DATA_WIDTH-1:0]   rd_s1_q;
    logic                    rd_s1_v_q;
    logic                    wr_fire;
    logic                    rd_fire;

    assign init_busy = (state_q == CLEAR);
    assign wr_fire   = !init_busy && wr_en;
    assign rd_fire   = !init_busy && rd_en;

    // Lane-merged word: disabled lanes keep the stored value.
    always_comb begin
        wr_word_d = mem_q[wr_addr];
        for (int i = 0; i < NUM_BE; i++)
            if (wr_be[i]) wr_word_d[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    assign rd_word_d = (RDW_MODE == 0 && wr_fire && wr_addr == rd_addr) ? wr_word_d : mem_q[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            if (&clr_cnt_q) state_q <= RUN;
            else clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (init_busy) mem_q[clr_cnt_q] <= '0;
        else if (wr_fire) mem_q[wr_addr] <= wr_word_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1_v_q <= 1'b0;
            rd_s1_q   <= '0;
        end else begin
            rd_s1_v_q <= rd_fire;
            if (rd_fire) rd_s1_q <= rd_word_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= '0;
                end else begin
                    rd_valid_q <= rd_s1_v_q;
                    if (rd_s1_v_q) rd_data_q <= rd_s1_q;
                end
            end
            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_noreg
            assign rd_data  = rd_s1_q;
            assign rd_valid = rd_s1_v_q;
        end
    endgenerate
endmodule

// File: tb/tb_ram_dp_mem.sv
// tb_ram_dp_mem: directed bench driving three configurations in lockstep:
// u0 8-bit new-data latency 1, u1 8-bit old-data latency 2, u2 32-bit byte-lane latency 1.
module tb_ram_dp_mem;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [5:0]  wr_addr;
    logic [5:0]  rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [7:0]  d0, d1;
    logic [31:0] d2;
    logic        v0, v1, v2;
    logic        b0, b1, b2;
    int          n_chk = 0;
    int          n_fail = 0;

    ram_dp_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .BYTE_WIDTH(8), .RDW_MODE(0), .OUT_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
        .wr_be(wr_be[0:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0), .init_busy(b0)
    );
    ram_dp_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .BYTE_WIDTH(8), .RDW_MODE(1), .OUT_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
        .wr_be(wr_be[0:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1), .init_busy(b1)
    );
    ram_dp_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8), .RDW_MODE(0), .OUT_REG(0)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d2), .rd_valid(v2), .init_busy(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0;
    endtask

    // Any write already set up by the caller shares the read's edge.
    task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [31:0] e2);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        check({tag, "_v0"}, v0, 1);
        check({tag, "_d0"}, d0, e0);
        check({tag, "_v2"}, v2, 1);
        check({tag, "_d2"}, d2, e2);
        check({tag, "_v1early"}, v1, 0);
        step();
        check({tag, "_v1"}, v1, 1);
        check({tag, "_d1"}, d1, e1);
        check({tag, "_v0off"}, v0, 0);
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        int vs = 0;
        while (b0 && n < 200) begin
            step();
            n++;
            vs += int'(v0 | v1 | v2);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check({tag, "_edges"}, n, 64);
        check({tag, "_busy12"}, {b1, b2}, 0);
        check({tag, "_novalid"}, vs, 0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
        step(); step();
        check("rst_busy", {b0, b1, b2}, 3'b111);
        check("rst_valid", {v0, v1, v2}, 0);
        check("rst_d0", d0, 0);
        check("rst_d1", d1, 0);
        check("rst_d2", d2, 0);

        // Requests held during the whole clear must be dropped.
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 6'd7;
        wait_clear("clr1");
        rd("rd7", 6'd7, 8'h00, 8'h00, 32'h0);

        for (int i = 0; i <= 64; i++) begin
            rd_en = (i < 64); rd_addr = i[5:0];
            step();
            if (i < 64) begin
                check("clr_v0", v0, 1);
                check("clr_d0", d0, 0);
                check("clr_d2", d2, 0);
            end
            if (i > 0) begin
                check("clr_v1", v1, 1);
                check("clr_d1", d1, 0);
            end
        end
        rd_en = 1'b0;
        step();
        check("clr_idle", {v0, v1, v2}, 0);

        wr(6'd5, 32'hAABBCCDD, 4'hF);
        wr(6'd5, 32'h11223344, 4'b0101);
        rd("be", 6'd5, 8'h44, 8'h44, 32'hAA22CC44);
        wr(6'd5, 32'hFFFFFFFF, 4'h0);
        rd("be0", 6'd5, 8'h44, 8'h44, 32'hAA22CC44);

        wr(6'd9, 32'h1122333C, 4'hF);
        wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'h55AA66A5; wr_be = 4'b0101;
        rd("rdw", 6'd9, 8'hA5, 8'h3C, 32'h11AA33A5);
        rd("rdw_after", 6'd9, 8'hA5, 8'hA5, 32'h11AA33A5);
        wr_en = 1'b1; wr_addr = 6'd10; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        rd("rdw_diff", 6'd9, 8'hA5, 8'hA5, 32'h11AA33A5);
        rd("rd10", 6'd10, 8'hEF, 8'hEF, 32'hDEADBEEF);

        for (int i = 0; i < 4; i++) wr(i[5:0], 32'h10 + i, 4'hF);
        for (int j = 0; j < 6; j++) begin
            rd_en = (j < 4); rd_addr = j[5:0];
            step();
            check("str_v0", v0, j < 4);
            check("str_d0", d0, j < 4 ? 32'h10 + j : 32'h13);
            check("str_d2", d2, j < 4 ? 32'h10 + j : 32'h13);
            check("str_v1", v1, j >= 1 && j <= 4);
            if (j >= 1) check("str_d1", d1, j <= 4 ? 32'h10 + j - 1 : 32'h13);
        end
        rd_en = 1'b0;

        // Reset while u1 still has the read in flight.
        wr(6'd2, 32'h77, 4'hF);
        rd_en = 1'b1; rd_addr = 6'd2;
        step();
        rd_en = 1'b0;
        check("pre_rst_v0", v0, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {v0, v1, v2}, 0);
        check("mid_rst_d0", d0, 0);
        check("mid_rst_d2", d2, 0);
        check("mid_rst_busy", {b0, b1, b2}, 3'b111);
        step(); step();
        check("mid_rst_v1", v1, 0);
        check("mid_rst_d1", d1, 0);
        rst_n = 1'b1;
        wait_clear("clr2");
        rd("rst_rd2", 6'd2, 8'h00, 8'h00, 32'h0);

        // Reset during clear restarts the sweep from address 0.
        wr(6'd63, 32'hCAFEF00D, 4'hF);
        rd("rd63", 6'd63, 8'h0D, 8'h0D, 32'hCAFEF00D);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("clr_mid_busy", b0, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_clear("clr3");
        rd("clr3_rd63", 6'd63, 8'h00, 8'h00, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
